// File: rtl/ex_div_unit.sv
// rtl/ex_div_unit.sv - iterative 32-bit restoring divider (DIV/DIVU) for the EX stage
// Optional macro DIV_FAST_ZERO_EN: zero divisor/dividend completes one cycle after start.
module ex_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        stall_req
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_next;
  logic [4:0]  cnt;
  logic [31:0] part_rem;
  logic [31:0] quo_sh;
  logic [31:0] dvsr;
  logic [31:0] raw_dividend;
  logic        neg_q, neg_r, div_zero;

  logic [31:0] abs_dividend, abs_divisor;
  logic [32:0] shifted;
  logic        fits;
  logic [31:0] diff;
  logic [31:0] rem_next, quo_next;
  logic [31:0] fin_q, fin_r;
  logic        fast_zero;
  logic [31:0] fast_q, fast_r;

  // One restoring step: shift {rem, quo} left, trial-subtract the divisor.
  always_comb begin
    abs_dividend = (signed_op && dividend[31]) ? -dividend : dividend;
    abs_divisor  = (signed_op && divisor[31])  ? -divisor  : divisor;
    shifted      = {part_rem, quo_sh[31]};
    fits         = (shifted >= {1'b0, dvsr});
    diff         = shifted[31:0] - dvsr;
    rem_next     = fits ? diff : shifted[31:0];
    quo_next     = {quo_sh[30:0], fits};
    fin_q        = div_zero ? 32'hFFFF_FFFF : (neg_q ? -quo_next : quo_next);
    fin_r        = div_zero ? raw_dividend  : (neg_r ? -rem_next : rem_next);
  end

`ifdef DIV_FAST_ZERO_EN
  always_comb begin
    fast_zero = start && ((divisor == 32'd0) || (dividend == 32'd0));
    fast_q    = (divisor == 32'd0) ? 32'hFFFF_FFFF : 32'd0;
    fast_r    = (divisor == 32'd0) ? dividend      : 32'd0;
  end
`else
  always_comb begin
    fast_zero = 1'b0;
    fast_q    = 32'd0;
    fast_r    = 32'd0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state == BUSY);
    done       = (state == DONE);
    stall_req  = (start && (state == IDLE)) || (state == BUSY);
    case (state)
      IDLE:    if (start) state_next = fast_zero ? DONE : BUSY;
      BUSY:    if (cnt == 5'd31) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (cancel) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= 5'd0;
      part_rem     <= 32'd0;
      quo_sh       <= 32'd0;
      dvsr         <= 32'd0;
      raw_dividend <= 32'd0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      div_zero     <= 1'b0;
      quotient     <= 32'd0;
      remainder    <= 32'd0;
    end else if (cancel) begin
      cnt <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            neg_q        <= signed_op && (dividend[31] ^ divisor[31]);
            neg_r        <= signed_op && dividend[31];
            dvsr         <= abs_divisor;
            quo_sh       <= abs_dividend;
            part_rem     <= 32'd0;
            raw_dividend <= dividend;
            div_zero     <= (divisor == 32'd0);
            cnt          <= 5'd0;
            if (fast_zero) begin
              quotient  <= fast_q;
              remainder <= fast_r;
            end
          end
        end
        BUSY: begin
          part_rem <= rem_next;
          quo_sh   <= quo_next;
          cnt      <= cnt + 5'd1;
          // Last iteration: results go straight to the output registers.
          if (cnt == 5'd31) begin
            quotient  <= fin_q;
            remainder <= fin_r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// tb/tb_ex_div_unit.sv - table-driven self-checking bench for ex_div_unit
module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, signed_op, cancel;
  logic [31:0] dividend, divisor;
  logic        busy, done, stall_req;
  logic [31:0] quotient, remainder;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] prev_q, prev_r;

  always #5 clk = ~clk;

  ex_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .cancel(cancel),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .stall_req(stall_req)
  );

  typedef struct packed {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one operation and follow it to completion, checking timing and results.
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input string nm);
    int n;
    int exp_lat;
    logic seq_ok;
    exp_lat = 33;
`ifdef DIV_FAST_ZERO_EN
    if (a == 32'd0 || b == 32'd0) exp_lat = 1;
`endif
    @(negedge clk);
    start = 1'b1; signed_op = s; dividend = a; divisor = b;
    #1;
    seq_ok = (stall_req === 1'b1);
    @(negedge clk);
    start = 1'b0; dividend = $urandom; divisor = $urandom; signed_op = ~s;
    n = 1;
    while (done !== 1'b1 && n < 100) begin
      if (stall_req !== 1'b1 || busy !== 1'b1) seq_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check({nm, " latency"}, n, exp_lat);
    check({nm, " stall/busy seq"}, {31'd0, seq_ok}, 32'd1);
    check({nm, " stall at done"}, {31'd0, stall_req}, 32'd0);
    check({nm, " quotient"}, quotient, eq);
    check({nm, " remainder"}, remainder, er);
    @(negedge clk);
    check({nm, " done/busy after"}, {30'd0, done, busy}, 32'd0);
    prev_q = eq;
    prev_r = er;
  endtask

  initial begin
    int n;
    logic seen_done;

    vecs[0]  = '{1'b0, 32'd7,        32'd2,        32'd3,        32'd1};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
    vecs[2]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0};
    vecs[3]  = '{1'b0, 32'h12345678, 32'd0,        32'hFFFFFFFF, 32'h12345678};
    vecs[4]  = '{1'b1, 32'h12345678, 32'd0,        32'hFFFFFFFF, 32'h12345678};
    vecs[5]  = '{1'b0, 32'd100,      32'd7,        32'd14,       32'd2};
    vecs[6]  = '{1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE};
    vecs[7]  = '{1'b1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2};
    vecs[8]  = '{1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0};
    vecs[9]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    vecs[10] = '{1'b0, 32'd0,        32'd5,        32'd0,        32'd0};
    vecs[11] = '{1'b1, 32'h80000000, 32'd0,        32'hFFFFFFFF, 32'h80000000};
    vecs[12] = '{1'b1, 32'h80000000, 32'd2,        32'hC0000000, 32'd0};
    vecs[13] = '{1'b0, 32'h12345678, 32'h10,       32'h01234567, 32'd8};

    rst = 1'b1; start = 1'b0; signed_op = 1'b0; cancel = 1'b0;
    dividend = 32'd0; divisor = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset quotient", quotient, 32'd0);
    check("reset remainder", remainder, 32'd0);
    check("reset stall_req", {31'd0, stall_req}, 32'd0);

    for (int i = 0; i < 14; i++)
      do_op(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, $sformatf("vec%0d", i));

    // Cancel at k+10: back to IDLE next cycle, no done, old results kept.
    @(negedge clk);
    start = 1'b1; signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel busy", {31'd0, busy}, 32'd0);
    check("cancel done", {31'd0, done}, 32'd0);
    check("cancel quotient", quotient, prev_q);
    check("cancel remainder", remainder, prev_r);
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    check("cancel no done", {31'd0, seen_done}, 32'd0);

    // A second start during BUSY must not disturb the first operation.
    @(negedge clk);
    start = 1'b1; signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    repeat (4) begin @(negedge clk); n++; end
    start = 1'b1; signed_op = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(negedge clk);
    start = 1'b0;
    n++;
    while (done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("ignored start latency", n, 33);
    check("ignored start quotient", quotient, 32'd14);
    check("ignored start remainder", remainder, 32'd2);
    @(negedge clk);
    check("ignored start idle", {30'd0, done, busy}, 32'd0);

    // Reset mid-operation clears every output.
    @(negedge clk);
    start = 1'b1; signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst quotient", quotient, 32'd0);
    check("rst remainder", remainder, 32'd0);
    check("rst stall_req", {31'd0, stall_req}, 32'd0);
    do_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, "after rst 9/3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
